// File: rtl/line_mask_gen.sv
// Line raster/mask generator: streams one column-major frame of pixel coordinates with a mask
// marking an incrementally (DDA) rasterised line. Define LINE_THICK_EN for a 3-pixel-wide line.
module line_mask_gen #(
  parameter int H_ACTIVE   = 240,
  parameter int V_ACTIVE   = 320,
  parameter int FRAC_BITS  = 2,
  parameter int ACC_W      = 24,
  parameter int GAP_CYCLES = 10
) (
  input  logic              clk_65mhz,
  input  logic              rst_in_n,
  input  logic              param_valid,
  output logic              param_ready,
  input  logic signed [8:0] slope,
  input  logic signed [8:0] offset,
  input  logic              vert,
  output logic [10:0]       hcount,
  output logic [9:0]        vcount,
  output logic              pix_valid,
  output logic              mask_cr,
  output logic              frame_start,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam int          GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                  state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [10:0]             h_q, h_d;
  logic [9:0]              v_q, v_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [8:0]       slope_q, slope_d;
  logic signed [8:0]       offset_q, offset_d;
  logic                    vert_q, vert_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    mask_q, mask_d;
  logic                    start_q, start_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;

  logic accept, last_pix, gap_done;

  assign accept   = (state_q == IDLE) && ready_q && param_valid;
  assign last_pix = (state_q == RUN) && (h_q == H_LAST) && (v_q == V_LAST);
  assign gap_done = (state_q == GAP) && (gap_q == GAP_LAST);

  // State register plus every registered output and datapath register.
  always_ff @(posedge clk_65mhz or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      acc_q       <= '0;
      slope_q     <= '0;
      offset_q    <= '0;
      vert_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      mask_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of order.
      state_q     <= state_d;
      gap_q       <= gap_d;
      h_q         <= h_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      slope_q     <= slope_d;
      offset_q    <= offset_d;
      vert_q      <= vert_d;
      pix_valid_q <= pix_valid_d;
      mask_q      <= mask_d;
      start_q     <= start_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves the variable unassigned (no inferred latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (last_pix) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan counters and DDA accumulator; coordinates are held at zero outside RUN.
  always_comb begin
    slope_d  = slope_q;
    offset_d = offset_q;
    vert_d   = vert_q;
    acc_d    = acc_q;
    h_d      = '0;
    v_d      = '0;
    gap_d    = (state_q == GAP) ? gap_q + 1'b1 : '0;
    if (accept) begin
      slope_d  = slope;
      offset_d = offset;
      vert_d   = vert;
      acc_d    = {{(ACC_W-9){offset[8]}}, offset} <<< FRAC_BITS;
    end else if ((state_q == RUN) && !last_pix) begin
      if (v_q == V_LAST) begin
        h_d   = h_q + 1'b1;
        acc_d = acc_q + {{(ACC_W-9){slope_q[8]}}, slope_q};
      end else begin
        h_d = h_q;
        v_d = v_q + 1'b1;
      end
    end
  end

  // Mask is evaluated on the next pixel so it lines up with the registered coordinates.
  logic signed [ACC_W-1:0] target_d, dv, dh;
  logic                    hit_v, hit_h;

  assign target_d = acc_d >>> FRAC_BITS;
  assign dv = $signed({{(ACC_W-10){1'b0}}, v_d}) - target_d;
  assign dh = $signed({{(ACC_W-11){1'b0}}, h_d}) - $signed({{(ACC_W-9){offset_d[8]}}, offset_d});

`ifdef LINE_THICK_EN
  assign hit_v = (dv == '0) || (dv == ACC_W'(1)) || (dv == '1);
  assign hit_h = (dh == '0) || (dh == ACC_W'(1)) || (dh == '1);
`else
  assign hit_v = (dv == '0);
  assign hit_h = (dh == '0);
`endif

  always_comb begin
    pix_valid_d = (state_d == RUN);
    ready_d     = (state_d == IDLE);
    start_d     = accept;
    done_d      = pix_valid_d && (h_d == H_LAST) && (v_d == V_LAST);
    mask_d      = pix_valid_d && (vert_d ? hit_h : hit_v);
  end

  assign param_ready = ready_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign pix_valid   = pix_valid_q;
  assign mask_cr     = mask_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_line_mask_gen.sv
// Self-checking bench for line_mask_gen on a 10x10 frame: directed and random lines against an
// arithmetic line model, back-to-back accept timing, and reset in the middle of a frame.
module tb_line_mask_gen;

  localparam int H    = 10;
  localparam int V    = 10;
  localparam int FRAC = 2;
  localparam int GAP  = 10;
  localparam int NPIX = H * V;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              param_valid = 1'b0;
  logic              vert = 1'b0;
  logic signed [8:0] slope = '0;
  logic signed [8:0] offset = '0;
  logic              param_ready, pix_valid, mask_cr, frame_start, frame_done;
  logic [10:0]       hcount;
  logic [9:0]        vcount;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  line_mask_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FRAC_BITS(FRAC), .ACC_W(24), .GAP_CYCLES(GAP)
  ) dut (
    .clk_65mhz  (clk),
    .rst_in_n   (rst_n),
    .param_valid(param_valid),
    .param_ready(param_ready),
    .slope      (slope),
    .offset     (offset),
    .vert       (vert),
    .hcount     (hcount),
    .vcount     (vcount),
    .pix_valid  (pix_valid),
    .mask_cr    (mask_cr),
    .frame_start(frame_start),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  // Reference line: target row is floor(offset + h*slope/2^FRAC), computed in plain integers.
  function automatic bit near(int d);
`ifdef LINE_THICK_EN
    return (d >= -1) && (d <= 1);
`else
    return d == 0;
`endif
  endfunction

  function automatic bit model_pix(int h, int v, int s, int o, bit vt);
    int scale, num, t;
    scale = 1 << FRAC;
    if (vt) return near(h - o);
    num = o * scale + h * s;
    t = num / scale;
    if ((num % scale) != 0 && num < 0) t = t - 1;
    return near(v - t);
  endfunction

  // Observation state filled by sample(), one negedge per call.
  bit obs [0:1][0:H-1][0:V-1];
  int n_valid, n_pulse, n_start, n_done, order_err, idle_err, start_bad, done_bad;
  int ready_in_frame, pix_k, slot, first_done_cyc, start_cyc, accept_cyc;

  task automatic clear_mon();
    n_valid = 0; n_pulse = 0; n_start = 0; n_done = 0; order_err = 0; idle_err = 0;
    start_bad = 0; done_bad = 0; ready_in_frame = 0; pix_k = 0; slot = 0;
    first_done_cyc = -1; start_cyc = -1; accept_cyc = -1;
    foreach (obs[f, h, v]) obs[f][h][v] = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    if (pix_valid === 1'b1) begin
      if (frame_start === 1'b1) begin
        n_start++;
        slot = (n_start - 1) % 2;
        start_cyc = cyc;
        if (pix_k != 0) start_bad++;
      end
      if (int'(hcount) != pix_k / V || int'(vcount) != pix_k % V) order_err++;
      else obs[slot][pix_k / V][pix_k % V] = mask_cr;
      n_valid++;
      if (mask_cr === 1'b1) n_pulse++;
      if (frame_done === 1'b1) begin
        n_done++;
        if (n_done == 1) first_done_cyc = cyc;
        if (pix_k != NPIX - 1) done_bad++;
      end
      if (param_ready !== 1'b0) ready_in_frame++;
      pix_k = (pix_k + 1) % NPIX;
    end else begin
      if (mask_cr !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 ||
          hcount !== '0 || vcount !== '0) idle_err++;
      if (param_ready === 1'b1 && param_valid && accept_cyc < 0) accept_cyc = cyc;
    end
  endtask

  task automatic send(input int s, input int o, input bit vt, output bit timed_out);
    int b;
    b = 0;
    while (param_ready !== 1'b1 && b < 4 * GAP + 20) begin sample(); b++; end
    timed_out = (param_ready !== 1'b1);
    slope = 9'(s); offset = 9'(o); vert = vt; param_valid = 1'b1;
    sample();
    param_valid = 1'b0;
  endtask

  task automatic run_frame(input int s, input int o, input bit vt, output bit timed_out);
    int b;
    bit to;
    b = 0;
    send(s, o, vt, to);
    while (pix_valid === 1'b1 && b < NPIX + 20) begin sample(); b++; end
    timed_out = to || (b >= NPIX + 20);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({pix_valid, mask_cr, param_ready, frame_start, frame_done} !== 5'b0 ||
        hcount !== '0 || vcount !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid/mask/ready/start/done=%b h=%0d v=%0d, expected all 0",
               {pix_valid, mask_cr, param_ready, frame_start, frame_done}, hcount, vcount);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (param_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %b, expected 0", param_ready);
    end
    @(negedge clk);
    vectors++;
    if (param_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_edge: got %b, expected 1", param_ready);
    end
  endtask

  typedef struct {int s; int o; bit vt; int pulses;} vec_t;

  task automatic test_directed();
    vec_t tbl [5];
    bit   to, e;
    int   mm, exp_p;
    tbl = '{'{8, 1, 1'b0, 5}, '{-4, 7, 1'b0, 8}, '{1, 4, 1'b0, 10},
            '{0, 5, 1'b1, 10}, '{0, -1, 1'b1, 0}};
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      run_frame(tbl[i].s, tbl[i].o, tbl[i].vt, to);
      mm = 0; exp_p = 0;
      for (int h = 0; h < H; h++)
        for (int v = 0; v < V; v++) begin
          e = model_pix(h, v, tbl[i].s, tbl[i].o, tbl[i].vt);
          exp_p += int'(e);
          if (obs[0][h][v] !== e) mm++;
        end
      vectors++;
      if (to) begin miscompares++; $display("FAIL dir_timeout vec %0d: got timeout, expected frame", i); end
      vectors++;
      if (n_valid !== NPIX) begin
        miscompares++; $display("FAIL dir_valid_count vec %0d: got %0d, expected %0d", i, n_valid, NPIX);
      end
      vectors++;
      if (n_start !== 1 || start_bad !== 0) begin
        miscompares++; $display("FAIL dir_frame_start vec %0d: got %0d pulses (%0d misplaced), expected 1", i, n_start, start_bad);
      end
      vectors++;
      if (n_done !== 1 || done_bad !== 0) begin
        miscompares++; $display("FAIL dir_frame_done vec %0d: got %0d pulses (%0d misplaced), expected 1 at (9,9)", i, n_done, done_bad);
      end
      vectors++;
      if (order_err !== 0) begin
        miscompares++; $display("FAIL dir_scan_order vec %0d: got %0d out-of-order pixels, expected 0", i, order_err);
      end
      vectors++;
      if (mm !== 0) begin
        miscompares++; $display("FAIL dir_mask vec %0d: got %0d wrong pixels, expected 0", i, mm);
      end
      vectors++;
      if (n_pulse !== exp_p) begin
        miscompares++; $display("FAIL dir_pulses vec %0d: got %0d, expected %0d", i, n_pulse, exp_p);
      end
`ifndef LINE_THICK_EN
      vectors++;
      if (n_pulse !== tbl[i].pulses) begin
        miscompares++; $display("FAIL dir_pulses_table vec %0d: got %0d, expected %0d", i, n_pulse, tbl[i].pulses);
      end
`endif
      vectors++;
      if (idle_err !== 0) begin
        miscompares++; $display("FAIL dir_idle_outputs vec %0d: got %0d dirty idle cycles, expected 0", i, idle_err);
      end
    end
  endtask

  task automatic test_random();
    int  s, o, mm, exp_p;
    bit  vt, to, e;
    for (int i = 0; i < 8; i++) begin
      s  = int'($urandom_range(0, 40)) - 20;
      if ($urandom_range(0, 4) == 0) s = int'($urandom_range(0, 511)) - 256;
      o  = int'($urandom_range(0, 13)) - 2;
      vt = ($urandom_range(0, 3) == 0);
      clear_mon();
      run_frame(s, o, vt, to);
      mm = 0; exp_p = 0;
      for (int h = 0; h < H; h++)
        for (int v = 0; v < V; v++) begin
          e = model_pix(h, v, s, o, vt);
          exp_p += int'(e);
          if (obs[0][h][v] !== e) mm++;
        end
      vectors++;
      if (to || n_valid !== NPIX || n_done !== 1 || done_bad !== 0) begin
        miscompares++;
        $display("FAIL rnd_frame %0d (s=%0d o=%0d vt=%0d): got timeout=%0d valid=%0d done=%0d, expected 0/%0d/1",
                 i, s, o, vt, to, n_valid, n_done, NPIX);
      end
      vectors++;
      if (mm !== 0 || n_pulse !== exp_p) begin
        miscompares++;
        $display("FAIL rnd_mask %0d (s=%0d o=%0d vt=%0d): got %0d wrong pixels, %0d pulses, expected 0 wrong, %0d pulses",
                 i, s, o, vt, mm, n_pulse, exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sa, oa, ob, b, mm_a, mm_b;
    clear_mon();
    sa = int'($urandom_range(0, 16)) - 8;
    oa = int'($urandom_range(2, 7));
    ob = int'($urandom_range(0, 9));
    b = 0;
    while (param_ready !== 1'b1 && b < 4 * GAP + 20) begin sample(); b++; end
    slope = 9'(sa); offset = 9'(oa); vert = 1'b0; param_valid = 1'b1;
    sample();
    // A different parameter set is offered mid-frame and must not be taken until IDLE.
    slope = 9'(0); offset = 9'(ob); vert = 1'b1;
    b = 0;
    while (n_done < 2 && b < 2 * (NPIX + GAP) + 40) begin sample(); b++; end
    param_valid = 1'b0;
    mm_a = 0; mm_b = 0;
    for (int h = 0; h < H; h++)
      for (int v = 0; v < V; v++) begin
        if (obs[0][h][v] !== model_pix(h, v, sa, oa, 1'b0)) mm_a++;
        if (obs[1][h][v] !== model_pix(h, v, 0, ob, 1'b1)) mm_b++;
      end
    vectors++;
    if (n_done !== 2 || n_valid !== 2 * NPIX) begin
      miscompares++; $display("FAIL b2b_frames: got %0d done, %0d valid, expected 2, %0d", n_done, n_valid, 2 * NPIX);
    end
    vectors++;
    if (accept_cyc - first_done_cyc !== GAP + 1) begin
      miscompares++; $display("FAIL b2b_accept_gap: got %0d cycles, expected %0d", accept_cyc - first_done_cyc, GAP + 1);
    end
    vectors++;
    if (start_cyc - first_done_cyc !== GAP + 2) begin
      miscompares++; $display("FAIL b2b_start_gap: got %0d cycles, expected %0d", start_cyc - first_done_cyc, GAP + 2);
    end
    vectors++;
    if (ready_in_frame !== 0) begin
      miscompares++; $display("FAIL b2b_ready_in_run: got %0d cycles, expected 0", ready_in_frame);
    end
    vectors++;
    if (mm_a !== 0) begin
      miscompares++; $display("FAIL b2b_first_frame_mask: got %0d wrong pixels, expected 0", mm_a);
    end
    vectors++;
    if (mm_b !== 0) begin
      miscompares++; $display("FAIL b2b_second_frame_mask: got %0d wrong pixels, expected 0", mm_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b, dirty, mm;
    bit to;
    clear_mon();
    send(8, 1, 1'b0, to);
    b = 0;
    while (n_valid < 38 && b < 60) begin sample(); b++; end
    vectors++;
    if (hcount !== 11'd3 || vcount !== 10'd7 || mask_cr !== model_pix(3, 7, 8, 1, 1'b0)) begin
      miscompares++;
      $display("FAIL mid_pixel37: got h=%0d v=%0d mask=%b, expected h=3 v=7 mask=%b",
               hcount, vcount, mask_cr, model_pix(3, 7, 8, 1, 1'b0));
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pix_valid, mask_cr, param_ready} !== 3'b000) begin
      miscompares++; $display("FAIL mid_async_clear: got valid/mask/ready=%b, expected 000", {pix_valid, mask_cr, param_ready});
    end
    dirty = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || pix_valid !== 1'b0) dirty++;
    end
    vectors++;
    if (dirty !== 0) begin
      miscompares++; $display("FAIL mid_no_done: got %0d active cycles in reset, expected 0", dirty);
    end
    rst_n = 1'b1;
    clear_mon();
    run_frame(8, 1, 1'b0, to);
    mm = 0;
    for (int h = 0; h < H; h++)
      for (int v = 0; v < V; v++)
        if (obs[0][h][v] !== model_pix(h, v, 8, 1, 1'b0)) mm++;
    vectors++;
    if (to || n_start !== 1 || start_bad !== 0 || n_valid !== NPIX || n_done !== 1) begin
      miscompares++;
      $display("FAIL mid_restart: got timeout=%0d start=%0d misplaced=%0d valid=%0d done=%0d, expected 0/1/0/%0d/1",
               to, n_start, start_bad, n_valid, n_done, NPIX);
    end
    vectors++;
    if (mm !== 0) begin
      miscompares++; $display("FAIL mid_restart_mask: got %0d wrong pixels, expected 0", mm);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
